// File: rtl/zeroskip_expander.sv
// zeroskip_expander: rebuilds dense activation groups from packed nonzero bytes and znz bitmaps
//   clk, rst           : clock, synchronous active-high reset
//   group_nz_sel       : sparsity budget select (1 = 8:16, 0 = 4:16)
//   nz_din/nz_last_i/nz_vld_i/nz_rdy_o      : compressed nonzero-byte stream, lane 0 oldest
//   znz_din/znz_last_i/znz_vld_i/znz_rdy_o  : one zero/nonzero bitmap per group
//   dense_dout/dense_last_o/dense_vld_o/dense_rdy_i : registered expanded group
//   budget_err_o       : sticky flag, a group exceeded the selected budget
//   group_cnt_o        : number of groups handed off downstream
module zeroskip_expander #(
    parameter int GROUP_SIZE = 16,
    parameter int DATA_W     = 8,
    parameter int NZ_LANES   = 8,
    parameter int BUF_DEPTH  = 16,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         group_nz_sel,
    input  logic [NZ_LANES*DATA_W-1:0]   nz_din,
    input  logic                         nz_last_i,
    input  logic                         nz_vld_i,
    output logic                         nz_rdy_o,
    input  logic [GROUP_SIZE-1:0]        znz_din,
    input  logic                         znz_last_i,
    input  logic                         znz_vld_i,
    output logic                         znz_rdy_o,
    output logic [GROUP_SIZE*DATA_W-1:0] dense_dout,
    output logic                         dense_last_o,
    output logic                         dense_vld_o,
    input  logic                         dense_rdy_i,
    output logic                         budget_err_o,
    output logic [CNT_W-1:0]             group_cnt_o
);
    localparam int BUF_W  = BUF_DEPTH * DATA_W;
    localparam int FILL_W = $clog2(BUF_DEPTH + 1);
    localparam int POP_W  = $clog2(GROUP_SIZE + 1);

    logic [BUF_W-1:0]             buf_q, buf_d, shifted;
    logic [FILL_W-1:0]            fill_q, fill_d, base;
    logic                         tail_q, tail_d;
    logic [GROUP_SIZE*DATA_W-1:0] dout_q, dout_d, expanded;
    logic                         vld_q, vld_d, last_q, last_d, err_q, err_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [POP_W-1:0]             pop, pop_fire, budget;
    logic                         fire, accept, flush;
    int                           k;

    always_comb begin
        pop       = POP_W'($countones(znz_din));
        budget    = group_nz_sel ? POP_W'(GROUP_SIZE / 2) : POP_W'(GROUP_SIZE / 4);
        // Accept readiness ignores same-cycle drain so it never depends on the fire path.
        nz_rdy_o  = (int'(fill_q) <= BUF_DEPTH - NZ_LANES) && !tail_q && !rst;
        accept    = nz_vld_i && nz_rdy_o;
        fire      = znz_vld_i && (int'(fill_q) >= int'(pop)) && (!vld_q || dense_rdy_i) && !rst;
        znz_rdy_o = fire;
        flush     = fire && znz_last_i;
        pop_fire  = fire ? pop : '0;
        // Bytes above fill are kept zero, so an OR is enough to append a beat.
        shifted   = flush ? '0 : buf_q >> (int'(pop_fire) * DATA_W);
        base      = flush ? '0 : fill_q - FILL_W'(pop_fire);
        buf_d     = accept ? (shifted | (BUF_W'(nz_din) << (int'(base) * DATA_W))) : shifted;
        fill_d    = base + (accept ? FILL_W'(NZ_LANES) : '0);
        tail_d    = (accept && nz_last_i) || (tail_q && !flush);
        // Element i takes the k-th buffered byte, k = number of set bits below i.
        k = 0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            expanded[i*DATA_W +: DATA_W] = znz_din[i] ? buf_q[k*DATA_W +: DATA_W] : '0;
            k = k + int'(znz_din[i]);
        end
        dout_d = fire ? expanded : dout_q;
        vld_d  = fire || (vld_q && !dense_rdy_i);
        last_d = fire ? znz_last_i : last_q;
        err_d  = err_q || (fire && (pop > budget));
        cnt_d  = cnt_q + CNT_W'(vld_q && dense_rdy_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            fill_q <= '0;
            tail_q <= 1'b0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            last_q <= last_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dense_dout   = dout_q;
    assign dense_vld_o  = vld_q;
    assign dense_last_o = last_q;
    assign budget_err_o = err_q;
    assign group_cnt_o  = cnt_q;
endmodule
